// File: rtl/pattern_sequencer_pkg.sv
// Shared game constants, lane colours and sequencer state.
// Also holds the LFSR step and the random-note shaping.
package pattern_sequencer_pkg;

  localparam int LANES = 4;
  localparam int SONG_LEN = 64;
  localparam int IDX_W = 6;
  localparam int CNT_W = 8;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    LANE_GREEN,
    LANE_RED,
    LANE_YELLOW,
    LANE_BLUE
  } lane_t;

  typedef enum logic [1:0] {
    IDLE,
    SERVE,
    DONE
  } state_t;

  // Fibonacci step, taps 16,14,13,11.
  function automatic logic [15:0] lfsr_step(
    input logic [15:0] l
  );
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // A blank nibble becomes a single note so the
  // random stream never produces an empty row.
  function automatic logic [LANES-1:0] rand_pattern(
    input logic [5:0] l
  );
    logic [LANES-1:0] p;
    p = l[3:0];
    if (p == '0)
      p = 4'b0001 << l[5:4];
    return p;
  endfunction

endpackage

// File: rtl/pattern_sequencer_if.sv
// Control and pattern bundle between the pattern stage
// and its sequencer.
interface pattern_sequencer_if;
  import pattern_sequencer_pkg::*;

  logic             start;
  logic             pause;
  logic             mode;
  logic             req;
  logic [LANES-1:0] command_out;
  logic             valid;
  logic             song_done;
  logic [IDX_W-1:0] index;
  logic [CNT_W-1:0] notes_served;

  modport master (
    output start,
    output pause,
    output mode,
    output req,
    input  command_out,
    input  valid,
    input  song_done,
    input  index,
    input  notes_served
  );

  modport slave (
    input  start,
    input  pause,
    input  mode,
    input  req,
    output command_out,
    output valid,
    output song_done,
    output index,
    output notes_served
  );

endinterface

// File: rtl/pattern_sequencer_song_rom.sv
// Fixed song table; swap contents here to change the song.
// Pure combinational lookup, entry 0 is played first.
module pattern_sequencer_song_rom
  import pattern_sequencer_pkg::*;
(
  input  logic [IDX_W-1:0] addr,
  output logic [LANES-1:0] data
);

  localparam logic [3:0] SONG [64] = '{
    4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h0, 4'h5, 4'hA,
    4'hC, 4'h0, 4'h6, 4'h9, 4'hF, 4'h1, 4'h0, 4'h8,
    4'h2, 4'h4, 4'h0, 4'h3, 4'hC, 4'h5, 4'hA, 4'h0,
    4'h1, 4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h0,
    4'h9, 4'h6, 4'h0, 4'hF, 4'h3, 4'hC, 4'h5, 4'hA,
    4'h0, 4'h7, 4'hE, 4'hB, 4'hD, 4'h0, 4'h1, 4'h8,
    4'h2, 4'h4, 4'h8, 4'h0, 4'h6, 4'h3, 4'h9, 4'hC,
    4'h0, 4'h5, 4'hA, 4'hF, 4'h1, 4'h2, 4'h4, 4'h8
  };

  assign data = SONG[addr];

endmodule

// File: rtl/pattern_sequencer.sv
// Feeds note patterns to the falling-note stage from the
// song table or the LFSR, one per swap request.
module pattern_sequencer
  import pattern_sequencer_pkg::*;
(
  input  logic              CLOCK_25,
  input  logic              reset_n,
  pattern_sequencer_if.slave bus
);

  state_t           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic             req_d;
  logic             pending_q, pending_d;
  logic             mode_q, mode_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [LANES-1:0] cmd_q, cmd_d;
  logic [CNT_W-1:0] served_q, served_d;

  logic [IDX_W-1:0] rom_addr;
  logic [LANES-1:0] rom_data;
  logic [15:0]      lfsr_run;
  logic [15:0]      lfsr_first;
  logic             req_rise;
  logic             serve;
  logic             last;

  assign req_rise   = bus.req & ~req_d;
  assign serve      = (state_q == SERVE)
                    & (req_rise | pending_q)
                    & ~bus.pause
                    & ~bus.start;
  assign last       = index_q == IDX_W'(SONG_LEN - 1);
  assign lfsr_run   = lfsr_step(lfsr_q);
  assign lfsr_first = lfsr_step(LFSR_SEED);

  // Start always reads entry 0; a service reads the next one.
  assign rom_addr = bus.start ? '0 : index_q + IDX_W'(1);

  pattern_sequencer_song_rom u_rom (
    .addr (rom_addr),
    .data (rom_data)
  );

  // State and output registers.
  always_ff @(posedge CLOCK_25 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      lfsr_q    <= LFSR_SEED;
      req_d     <= 1'b0;
      pending_q <= 1'b0;
      mode_q    <= 1'b0;
      index_q   <= '0;
      cmd_q     <= '0;
      served_q  <= '0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      req_d     <= bus.req;
      pending_q <= pending_d;
      mode_q    <= mode_d;
      index_q   <= index_d;
      cmd_q     <= cmd_d;
      served_q  <= served_d;
    end
  end

  // Next state: start wins, then service, else pend.
  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    pending_d = pending_q;
    mode_d    = mode_q;
    index_d   = index_q;
    cmd_d     = cmd_q;
    served_d  = served_q;
    unique case (1'b1)
      bus.start: begin
        state_d   = SERVE;
        mode_d    = bus.mode;
        index_d   = '0;
        pending_d = 1'b0;
        served_d  = CNT_W'(1);
        if (bus.mode) begin
          lfsr_d = lfsr_first;
          cmd_d  = rand_pattern(lfsr_first[5:0]);
        end else begin
          lfsr_d = LFSR_SEED;
          cmd_d  = rom_data;
        end
      end
      serve: begin
        pending_d = 1'b0;
        if (served_q != '1)
          served_d = served_q + CNT_W'(1);
        if (mode_q) begin
          lfsr_d = lfsr_run;
          cmd_d  = rand_pattern(lfsr_run[5:0]);
        end else if (last) begin
          state_d = DONE;
          cmd_d   = '0;
        end else begin
          index_d = index_q + IDX_W'(1);
          cmd_d   = rom_data;
        end
      end
      default: begin
        if (state_q == SERVE && req_rise && bus.pause)
          pending_d = 1'b1;
      end
    endcase
  end

  assign bus.command_out  = cmd_q;
  assign bus.valid        = state_q == SERVE;
  assign bus.song_done    = state_q == DONE;
  assign bus.index        = index_q;
  assign bus.notes_served = served_q;

endmodule
